// File: rtl/spi_tx_pkg.sv
// spi_tx_pkg: shared state encoding, SPI mode constants and word-length helper for spi_slave_tx_stream
// Optional: SPI_TX_PARITY_EN makes every word one bit longer (trailing even-parity bit).
package spi_tx_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;
    function automatic int word_bits(input int data_w);
`ifdef SPI_TX_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises SCK and CS_N into clk and produces single-cycle edge pulses
// Ports: clk/rst system clock and async reset; sck/cs_n raw pins;
//        lead/trail SCK edge pulses relative to CPOL; cs_fall/cs_rise chip-select pulses.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs_n,
    output logic lead,
    output logic trail,
    output logic cs_fall,
    output logic cs_rise
);
    logic [SYNC_STAGES-1:0] sck_s;
    logic [SYNC_STAGES-1:0] cs_s;
    logic sck_rise;
    logic sck_fall;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s <= {SYNC_STAGES{CPOL}};
            cs_s  <= '1;
        end else begin
            sck_s <= {sck_s[SYNC_STAGES-2:0], sck};
            cs_s  <= {cs_s[SYNC_STAGES-2:0], cs_n};
        end
    end
    // Edges are taken between the two oldest stages so only settled values are compared.
    assign sck_rise = sck_s[SYNC_STAGES-2] & ~sck_s[SYNC_STAGES-1];
    assign sck_fall = ~sck_s[SYNC_STAGES-2] & sck_s[SYNC_STAGES-1];
    assign lead     = CPOL ? sck_fall : sck_rise;
    assign trail    = CPOL ? sck_rise : sck_fall;
    assign cs_fall  = ~cs_s[SYNC_STAGES-2] & cs_s[SYNC_STAGES-1];
    assign cs_rise  = cs_s[SYNC_STAGES-2] & ~cs_s[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave_tx_stream.sv
// spi_slave_tx_stream: SPI slave transmitter with one-deep holding buffer and seamless word streaming
// Ports: clk/rst system clock and async reset; tx_data/tx_valid/tx_ready word handshake;
//        spi_cs_n/spi_sck raw SPI pins; spi_miso/spi_miso_oe registered pad drive;
//        frame_done/frame_abort/underrun single-cycle status pulses.
// Optional: define SPI_TX_PARITY_EN to append an even-parity bit after every word.
module spi_slave_tx_stream
    import spi_tx_pkg::*;
#(
    parameter int                DATA_W        = 64,
    parameter bit                CPOL          = 1'b0,
    parameter bit                CPHA          = 1'b0,
    parameter bit                MSB_FIRST     = 1'b1,
    parameter bit                MISO_IDLE     = 1'b1,
    parameter logic [DATA_W-1:0] UNDERRUN_WORD = '1,
    parameter int                SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underrun
);
    localparam int WB = word_bits(DATA_W);
    localparam int CW = $clog2(WB);
    localparam logic [CW-1:0] LAST = CW'(WB - 1);
`ifdef SPI_TX_PARITY_EN
    localparam logic [CW-1:0] PAR_IDX = CW'(DATA_W);
    logic par_q, par_d;
`endif
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic started, started_d;
    logic [DATA_W-1:0] shreg, shreg_d, hold, hold_d, word;
    logic full, full_d;
    logic miso_d, oe_d, done_d, abort_d, under_d;
    logic reload, emit, emit_par, accept;
    logic lead, trail, cs_fall, cs_rise, shift_edge;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .CPOL(CPOL)) u_sync (
        .clk(clk), .rst(rst), .sck(spi_sck), .cs_n(spi_cs_n),
        .lead(lead), .trail(trail), .cs_fall(cs_fall), .cs_rise(cs_rise)
    );

    assign shift_edge = CPHA ? lead : trail;
    assign tx_ready   = ~full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            started     <= 1'b0;
            shreg       <= '0;
            hold        <= '0;
            full        <= 1'b0;
            spi_miso    <= MISO_IDLE;
            spi_miso_oe <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            underrun    <= 1'b0;
`ifdef SPI_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            started     <= started_d;
            shreg       <= shreg_d;
            hold        <= hold_d;
            full        <= full_d;
            spi_miso    <= miso_d;
            spi_miso_oe <= oe_d;
            frame_done  <= done_d;
            frame_abort <= abort_d;
            underrun    <= under_d;
`ifdef SPI_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // cnt counts shift edges modulo the word length, so a frame ended on a word
    // boundary is exactly "cnt == 0 after at least one edge" in every mode.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        started_d = started;
        miso_d    = spi_miso;
        oe_d      = spi_miso_oe;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        reload    = 1'b0;
        emit      = 1'b0;
        emit_par  = 1'b0;
        if (cs_rise) begin
            state_d   = IDLE;
            cnt_d     = '0;
            started_d = 1'b0;
            miso_d    = MISO_IDLE;
            oe_d      = 1'b0;
            done_d    = started && cnt == '0;
            abort_d   = !(started && cnt == '0);
        end else begin
            case (state)
                IDLE: state_d = cs_fall ? LOAD : IDLE;
                LOAD: begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    started_d = 1'b0;
                    oe_d      = 1'b1;
                    reload    = 1'b1;
                    emit      = !CPHA;
                end
                SHIFT: if (shift_edge) begin
                    started_d = 1'b1;
                    cnt_d     = (cnt == LAST) ? '0 : cnt + CW'(1);
                    emit      = 1'b1;
                    // CPHA=0 drives bit cnt+1 (first bit was driven in LOAD);
                    // CPHA=1 drives bit cnt, so its reload waits for the first edge of the next word.
                    reload    = CPHA ? (cnt == '0 && started) : (cnt == LAST);
`ifdef SPI_TX_PARITY_EN
                    emit_par  = CPHA ? (cnt == PAR_IDX) : (cnt == PAR_IDX - CW'(1));
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        word    = reload ? (full ? hold : UNDERRUN_WORD) : shreg;
        under_d = reload && !full;
        shreg_d = emit ? (MSB_FIRST ? {word[DATA_W-2:0], 1'b0} : {1'b0, word[DATA_W-1:1]}) : word;
        if (emit) miso_d = MSB_FIRST ? word[DATA_W-1] : word[0];
`ifdef SPI_TX_PARITY_EN
        par_d = reload ? ^word : par_q;
        if (emit_par) miso_d = par_q;
`endif
        accept = tx_valid && !full;
        full_d = accept || (full && !reload);
        hold_d = accept ? tx_data : hold;
    end
endmodule

// File: tb/tb_spi_slave_tx_stream.sv
// tb_spi_slave_tx_stream: scoreboard bench driving a mode-0/64-bit MSB-first and a mode-3/16-bit LSB-first slave
module tb_spi_slave_tx_stream;
    localparam int EV_U = 1;
    localparam int EV_D = 2;
    localparam int EV_A = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [63:0] txd_a = '0;
    logic [15:0] txd_b = '0;
    logic [1:0] v = '0, rdy, cs_n = 2'b11, sck = 2'b10, miso, oe, done, abort, under;

    int n_chk = 0;
    int n_pass = 0;
    bit exp_q [2][$];
    int exp_evt [2][$];
    logic [127:0] mbuf [2][$];

    always #5 clk = ~clk;

    spi_slave_tx_stream #(.DATA_W(64), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(txd_a), .tx_valid(v[0]), .tx_ready(rdy[0]),
        .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_miso(miso[0]), .spi_miso_oe(oe[0]),
        .frame_done(done[0]), .frame_abort(abort[0]), .underrun(under[0])
    );
    spi_slave_tx_stream #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .tx_data(txd_b), .tx_valid(v[1]), .tx_ready(rdy[1]),
        .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_miso(miso[1]), .spi_miso_oe(oe[1]),
        .frame_done(done[1]), .frame_abort(abort[1]), .underrun(under[1])
    );

    function automatic int dw(int k); return (k != 0) ? 16 : 64; endfunction
    function automatic int wb(int k);
`ifdef SPI_TX_PARITY_EN
        return dw(k) + 1;
`else
        return dw(k);
`endif
    endfunction
    function automatic bit cpol(int k); return k != 0; endfunction
    function automatic bit cpha(int k); return k != 0; endfunction
    function automatic bit msb(int k); return k == 0; endfunction
    function automatic logic [127:0] mask(int k); return (128'd1 << dw(k)) - 128'd1; endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: each word load takes the oldest buffered word or the all-ones
    // underrun word, and contributes its bits in wire order to the expected stream.
    task automatic model_load(int k);
        logic [127:0] w;
        if (mbuf[k].size() > 0) w = mbuf[k].pop_front();
        else begin
            w = mask(k);
            exp_evt[k].push_back(EV_U);
        end
        for (int i = 0; i < dw(k); i++) exp_q[k].push_back(w[msb(k) ? dw(k) - 1 - i : i]);
`ifdef SPI_TX_PARITY_EN
        exp_q[k].push_back(^(w & mask(k)));
`endif
    endtask

    task automatic push_word(int k, logic [127:0] w);
        int t = 0;
        @(negedge clk);
        if (k == 0) txd_a = w[63:0]; else txd_b = w[15:0];
        v[k] = 1'b1;
        while (!rdy[k] && t < 5000) begin @(negedge clk); t++; end
        chk("push ready", rdy[k], 1);
        if (rdy[k]) begin
            @(posedge clk);
            mbuf[k].push_back(w & mask(k));
            @(negedge clk);
        end
        v[k] = 1'b0;
    endtask

    task automatic do_reset(int k);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst miso", miso[k], 1);
        chk("rst oe", oe[k], 0);
        chk("rst tx_ready", rdy[k], 1);
        chk("rst pulses", {done[k], abort[k], under[k]}, 0);
        cs_n[k] = 1'b1;
        sck[k] = cpol(k);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mbuf[k].delete();
        exp_q[k].delete();
        exp_evt[k].delete();
    endtask

    task automatic frame(int k, int n, int rst_at);
        model_load(k);
        @(negedge clk);
        cs_n[k] = 1'b0;
        #200;
        for (int b = 0; b < n; b++) begin
            if (b == rst_at) begin
                do_reset(k);
                return;
            end
            if (cpha(k) && b > 0 && b % wb(k) == 0) model_load(k);
            sck[k] = ~cpol(k);
            #60;
            if (!cpha(k) && (b + 1) % wb(k) == 0) model_load(k);
            sck[k] = cpol(k);
            #60;
        end
        #60;
        exp_evt[k].push_back((n > 0 && n % wb(k) == 0) ? EV_D : EV_A);
        cs_n[k] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle miso", miso[k], 1);
        chk("idle oe", oe[k], 0);
        repeat (4) @(negedge clk);
        chk("pulses drained", exp_evt[k].size(), 0);
        chk("end tx_ready", rdy[k], mbuf[k].size() == 0);
        exp_q[k].delete();
    endtask

    task automatic pulse(int g, int code);
        int e;
        e = (exp_evt[g].size() > 0) ? exp_evt[g].pop_front() : 0;
        chk("status pulse", code, e);
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        always @(sck[g]) begin : bitmon
            logic [1:0] e;
            if (!rst && !cs_n[g] && sck[g] == (~cpol(g) ^ cpha(g))) begin
                e = (exp_q[g].size() > 0) ? {1'b0, exp_q[g].pop_front()} : 2'd2;
                chk("miso bit", miso[g], e);
                chk("frame oe", oe[g], 1);
            end
        end
        always @(negedge clk) begin
            if (!rst) begin
                if (under[g]) pulse(g, EV_U);
                if (done[g]) pulse(g, EV_D);
                if (abort[g]) pulse(g, EV_A);
            end
        end
    end

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset miso", miso[k], 1);
            chk("reset oe", oe[k], 0);
            chk("reset tx_ready", rdy[k], 1);
            chk("reset pulses", {done[k], abort[k], under[k]}, 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push_word(0, 128'hA5A5_0123_4567_89AB);
        frame(0, 64, -1);
        push_word(0, rnd());
        frame(0, 10, -1);
        frame(0, 64, -1);
        push_word(0, rnd());
        fork
            push_word(0, rnd());
            frame(0, 128, -1);
        join
        push_word(1, 128'h1234);
        fork
            push_word(1, 128'hBEEF);
            frame(1, 32, -1);
        join
        fork
            begin #(200 + 120 * (wb(1) / 2)); push_word(1, rnd()); end
            frame(1, 32, -1);
        join
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) begin
                int n;
                n = $urandom_range(3 * wb(k), 1);
                if (mbuf[k].size() == 0 && $urandom_range(1, 0) == 1) push_word(k, rnd());
                if (n > wb(k)) begin
                    fork
                        begin #(200 + 120 * (wb(k) / 2)); push_word(k, rnd()); end
                        frame(k, n, -1);
                    join
                end else frame(k, n, -1);
            end
        end
        while (mbuf[0].size() > 0) frame(0, 64, -1);
        push_word(0, rnd());
        fork
            push_word(0, rnd());
            frame(0, 64, 5);
        join
        repeat (10) @(negedge clk);
        chk("post-reset idle miso", miso[0], 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
